serial_ctrl: RTL

//  UART (8N1) serial-port controller on the memory-mapped serial interface driven by the MMU.

---
 rtl/serial_ctrl_if.sv | 28 ++
 rtl/serial_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_ctrl_if.sv
// MMU-side register bus of the UART controller: one access per enable_i cycle, status flags back.
// Fixed one-cycle access, no stall: the MMU polls sendComplete_o/receiveComplete_o instead of waiting.
interface serial_ctrl_if;
    logic        enable_i;
    logic        readWrite_i;
    logic [15:0] dataWrite_i;
    logic [15:0] dataRead_o;
    logic        sendComplete_o;
    logic        receiveComplete_o;

    modport master (
        output enable_i,
        output readWrite_i,
        output dataWrite_i,
        input  dataRead_o,
        input  sendComplete_o,
        input  receiveComplete_o
    );

    modport slave (
        input  enable_i,
        input  readWrite_i,
        input  dataWrite_i,
        output dataRead_o,
        output sendComplete_o,
        output receiveComplete_o
    );
endinterface

// File: rtl/serial_ctrl.sv
// 8N1 UART controller: CPU writes serialise onto uart_txd_o, uart_rxd_i fills a one-byte buffer.
// Frame = 10*CLKS_PER_BIT cycles; writes while busy are dropped, an unread byte is overwritten.
module serial_ctrl #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         rst,
    serial_ctrl_if.slave bus,
    input  logic         uart_rxd_i,
    output logic         uart_txd_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            txd_q, txd_d;
    logic            send_done_q, send_done_d;

    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_buf_q, rx_buf_d;
    logic            rx_done_q, rx_done_d;
    logic            rxd_meta_q, rxd_s_q;

    logic wr_stb, rd_stb;
    logic unused_wr_hi;

    assign wr_stb       = bus.enable_i & bus.readWrite_i;
    assign rd_stb       = bus.enable_i & ~bus.readWrite_i;
    assign unused_wr_hi = &{1'b0, bus.dataWrite_i[15:8]};

    assign uart_txd_o            = txd_q;
    assign bus.sendComplete_o    = send_done_q;
    assign bus.receiveComplete_o = rx_done_q;
    assign bus.dataRead_o        = {8'h00, rx_buf_q};

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        txd_d       = txd_q;
        send_done_d = send_done_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (wr_stb) begin
                    tx_state_d  = TX_START;
                    tx_cnt_d    = '0;
                    tx_shift_d  = bus.dataWrite_i[7:0];
                    txd_d       = 1'b0;
                    send_done_d = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        // Shift register keeps the bit on the line at [0]; [1] is next.
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d  = TX_IDLE;
                    tx_cnt_d    = '0;
                    send_done_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_buf_d   = rx_buf_q;
        rx_done_d  = rx_done_q;
        if (rd_stb) rx_done_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rxd_s_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rxd_s_q) begin
                        // A good byte beats a same-cycle read clear.
                        rx_buf_d   = rx_shift_q;
                        rx_done_d  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rxd_s_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            txd_q       <= 1'b1;
            send_done_q <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_buf_q    <= '0;
            rx_done_q   <= 1'b0;
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            txd_q       <= txd_d;
            send_done_q <= send_done_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_buf_q    <= rx_buf_d;
            rx_done_q   <= rx_done_d;
            rxd_meta_q  <= uart_rxd_i;
            rxd_s_q     <= rxd_meta_q;
        end
    end
endmodule
